// File: rtl/tag_resolver_if.sv
// Resolver-side bundle: command handshake, match lines in, tag/responder status out.
// The master side issues commands. The slave side (tag_resolver) owns tags and count.
interface tag_resolver_if #(
    parameter int WORDS = 100
);
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CNTW = $clog2(WORDS + 1);

    logic [WORDS-1:0] match_lines;
    logic [2:0]       cmd;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WORDS-1:0] tags;
    logic             some;
    logic [IDXW-1:0]  first_idx;
    logic [CNTW-1:0]  count;
    logic             count_valid;

    modport master (
        output match_lines, cmd, cmd_valid,
        input  cmd_ready, tags, some, first_idx, count, count_valid
    );

    modport slave (
        input  match_lines, cmd, cmd_valid,
        output cmd_ready, tags, some, first_idx, count, count_valid
    );
endinterface

// File: rtl/tag_resolver.sv
// Tag register with responder narrowing/isolation and a chunked popcount.
// Tag ops take effect at the accept edge. COUNT holds cmd_ready low for ceil(WORDS/CHUNK) cycles.
module tag_resolver #(
    parameter int WORDS = 100,
    parameter int CHUNK = 8
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    tag_resolver_if.slave  bus
);
    localparam int IDXW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CNTW   = $clog2(WORDS + 1);
    localparam int NCHUNK = (WORDS + CHUNK - 1) / CHUNK;
    localparam int PTRW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PADW   = NCHUNK * CHUNK;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_SET_ALL = 3'd1,
        OP_CLR_ALL = 3'd2,
        OP_AND     = 3'd3,
        OP_OR      = 3'd4,
        OP_SEL1ST  = 3'd5,
        OP_STEP    = 3'd6,
        OP_COUNT   = 3'd7
    } op_e;

    typedef enum logic {S_IDLE, S_CNT} state_e;

    state_e           state_q, state_d;
    logic [WORDS-1:0] tags_q, tags_d;
    logic [PTRW-1:0]  ptr_q, ptr_d;
    logic [CNTW-1:0]  acc_q, acc_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             cv_q, cv_d;

    logic             accept;
    logic [PADW-1:0]  tags_pad;
    logic [CHUNK-1:0] chunk_bits;
    logic [CNTW-1:0]  chunk_pop;
    logic [IDXW-1:0]  first_idx;

    assign accept = bus.cmd_valid && (state_q == S_IDLE);

    // Zero padding above WORDS makes the partial last chunk count only real words.
    assign tags_pad   = PADW'(tags_q);
    assign chunk_bits = CHUNK'(tags_pad >> (ptr_q * CHUNK));

    always_comb begin
        chunk_pop = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_pop = chunk_pop + CNTW'(chunk_bits[i]);
        end
    end

    always_comb begin
        first_idx = '0;
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (tags_q[i]) first_idx = IDXW'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        tags_d  = tags_q;
        ptr_d   = ptr_q;
        acc_d   = acc_q;
        count_d = count_q;
        cv_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    // Lowest-set-bit isolate/clear are no-ops on an empty tag set.
                    case (op_e'(bus.cmd))
                        OP_SET_ALL: tags_d = '1;
                        OP_CLR_ALL: tags_d = '0;
                        OP_AND:     tags_d = tags_q & bus.match_lines;
                        OP_OR:      tags_d = tags_q | bus.match_lines;
                        OP_SEL1ST:  tags_d = tags_q & (~tags_q + WORDS'(1));
                        OP_STEP:    tags_d = tags_q & (tags_q - WORDS'(1));
                        OP_COUNT: begin
                            state_d = S_CNT;
                            ptr_d   = '0;
                            acc_d   = '0;
                        end
                        default: ;
                    endcase
                end
            end
            S_CNT: begin
                acc_d = acc_q + chunk_pop;
                ptr_d = ptr_q + PTRW'(1);
                if (ptr_q == PTRW'(NCHUNK - 1)) begin
                    count_d = acc_q + chunk_pop;
                    cv_d    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            tags_q  <= '0;
            ptr_q   <= '0;
            acc_q   <= '0;
            count_q <= '0;
            cv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tags_q  <= tags_d;
            ptr_q   <= ptr_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            cv_q    <= cv_d;
        end
    end

    assign bus.cmd_ready   = (state_q == S_IDLE);
    assign bus.tags        = tags_q;
    assign bus.some        = |tags_q;
    assign bus.first_idx   = first_idx;
    assign bus.count       = count_q;
    assign bus.count_valid = cv_q;
endmodule

// File: tb/tb_tag_resolver.sv
// Directed bench for tag_resolver: vector table for tag ops, hand sequences for COUNT and reset abort.
module tb_tag_resolver;
    localparam int W = 100;
    localparam logic [2:0] NOP = 3'd0, SETA = 3'd1, CLRA = 3'd2, ANDM = 3'd3,
                           ORM = 3'd4, SEL1 = 3'd5, STEP = 3'd6, CNT = 3'd7;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    tag_resolver_if #(.WORDS(W)) bus ();

    tag_resolver #(.WORDS(W), .CHUNK(8)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   cmd;
        logic [W-1:0] match;
        logic [W-1:0] tags;
        logic         some;
        int           idx;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    function automatic logic [W-1:0] mk(input int a, input int b, input int c);
        logic [W-1:0] r;
        r = '0;
        if (a >= 0) r[a] = 1'b1;
        if (b >= 0) r[b] = 1'b1;
        if (c >= 0) r[c] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Drive one command for a single accept edge; match_lines is scrambled afterwards.
    task automatic apply(input logic [2:0] c, input logic [W-1:0] m);
        @(negedge clk);
        bus.cmd         = c;
        bus.match_lines = m;
        bus.cmd_valid   = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid   = 1'b0;
        bus.match_lines = ~m;
    endtask

    task automatic run_count(input int exp, input bit hold_clr, input logic [W-1:0] exp_tags);
        int low;
        bit early;
        low   = 0;
        early = 1'b0;
        @(negedge clk);
        bus.cmd       = CNT;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        if (hold_clr) bus.cmd = CLRA;
        else          bus.cmd_valid = 1'b0;
        while (!bus.cmd_ready && low < 60) begin
            low++;
            if (bus.count_valid) early = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        chk("cnt_busy_cycles", W'(low), W'(13));
        chk("cnt_no_early_valid", W'(early), W'(0));
        chk("cnt_valid_pulse", W'(bus.count_valid), W'(1));
        chk("cnt_value", W'(bus.count), W'(exp));
        @(posedge clk);
        #1;
        chk("cnt_valid_drop", W'(bus.count_valid), W'(0));
        chk("cnt_hold", W'(bus.count), W'(exp));
        chk("cnt_tags", bus.tags, exp_tags);
    endtask

    initial begin
        bit cv_seen;
        bit rdy_lost;
        total = 0;
        bad   = 0;

        vecs[0]  = '{SETA, '0,             '1,              1'b1, 0};
        vecs[1]  = '{ANDM, mk(3, 7, 50),   mk(3, 7, 50),    1'b1, 3};
        vecs[2]  = '{STEP, '0,             mk(7, 50, -1),   1'b1, 7};
        vecs[3]  = '{STEP, '0,             mk(50, -1, -1),  1'b1, 50};
        vecs[4]  = '{STEP, '0,             '0,              1'b0, 0};
        vecs[5]  = '{STEP, '0,             '0,              1'b0, 0};
        vecs[6]  = '{CLRA, '1,             '0,              1'b0, 0};
        vecs[7]  = '{ORM,  mk(99, 10, -1), mk(99, 10, -1),  1'b1, 10};
        vecs[8]  = '{SEL1, '0,             mk(10, -1, -1),  1'b1, 10};
        vecs[9]  = '{NOP,  '1,             mk(10, -1, -1),  1'b1, 10};
        vecs[10] = '{CLRA, '0,             '0,              1'b0, 0};
        vecs[11] = '{SEL1, '0,             '0,              1'b0, 0};
        vecs[12] = '{ORM,  mk(99, -1, -1), mk(99, -1, -1),  1'b1, 99};
        vecs[13] = '{ORM,  mk(0, -1, -1),  mk(0, 99, -1),   1'b1, 0};
        vecs[14] = '{ANDM, mk(99, -1, -1), mk(99, -1, -1),  1'b1, 99};
        vecs[15] = '{STEP, '0,             '0,              1'b0, 0};

        rst_n           = 1'b0;
        bus.cmd         = NOP;
        bus.cmd_valid   = 1'b0;
        bus.match_lines = '0;
        #3;
        chk("rst_tags", bus.tags, '0);
        chk("rst_some", W'(bus.some), W'(0));
        chk("rst_idx", W'(bus.first_idx), W'(0));
        chk("rst_count", W'(bus.count), W'(0));
        chk("rst_cv", W'(bus.count_valid), W'(0));
        chk("rst_ready", W'(bus.cmd_ready), W'(1));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i].cmd, vecs[i].match);
            chk($sformatf("v%0d_tags", i), bus.tags, vecs[i].tags);
            chk($sformatf("v%0d_some", i), W'(bus.some), W'(vecs[i].some));
            chk($sformatf("v%0d_idx", i), W'(bus.first_idx), W'(vecs[i].idx));
            chk($sformatf("v%0d_ready", i), W'(bus.cmd_ready), W'(1));
        end

        apply(SETA, '0);
        run_count(100, 1'b1, '1);
        apply(CLRA, '0);
        run_count(0, 1'b0, '0);
        apply(SETA, '0);
        run_count(100, 1'b0, '1);

        // Reset lands after chunk edge 5 of a COUNT over all-ones tags.
        @(negedge clk);
        bus.cmd       = CNT;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_tags", bus.tags, '0);
        chk("abort_some", W'(bus.some), W'(0));
        chk("abort_idx", W'(bus.first_idx), W'(0));
        chk("abort_count", W'(bus.count), W'(0));
        chk("abort_ready", W'(bus.cmd_ready), W'(1));
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        cv_seen  = 1'b0;
        rdy_lost = 1'b0;
        repeat (16) begin
            @(posedge clk);
            #1;
            if (bus.count_valid) cv_seen = 1'b1;
            if (!bus.cmd_ready) rdy_lost = 1'b1;
        end
        chk("abort_no_cv", W'(cv_seen), W'(0));
        chk("abort_idle", W'(rdy_lost), W'(0));
        chk("abort_count_after", W'(bus.count), W'(0));
        apply(SETA, '0);
        run_count(100, 1'b0, '1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tag_resolver.md
# tag_resolver

Tag register and multiple-response resolver for the associative processor array. It holds one tag bit per word and drives the `tags` bus of the cell array, which gates writes and reads per word. It consumes the array's `match_lines` to narrow or widen the responder set, and isolates responders one at a time (select-first / step). It also counts responders with a multi-cycle chunked popcount under a valid/ready command handshake.

## Interface
- `WORDS`, default 100: number of words in the array; width of `tags` and `match_lines`. Must be ≥ 1.
- `CHUNK`, default 8: tag bits summed per counting cycle. Must be ≥ 1.
- `CLK`  in  1  rising-edge clock shared with the cell array.
- `RST_N`  in  1  asynchronous, active-low reset.
- `match_lines`  in  WORDS  per-word search result from the cell array; combinational, sampled at the command accept edge.
- `cmd`  in  3  opcode; meaningful only while `cmd_valid` = 1.
- `cmd_valid`  in  1  a command is presented.
- `cmd_ready`  out  1  resolver can accept a command this cycle.
- `tags`  out  WORDS  tag register; connects to the cell array `tags` input.
- `some`  out  1  OR of `tags`; combinational from the tag register.
- `first_idx`  out  $clog2(WORDS)  index of the lowest set tag; 0 when `some` = 0.
- `count`  out  $clog2(WORDS+1)  result of the last completed COUNT.
- `count_valid`  out  1  one-cycle pulse when `count` is updated.

## Operation
- A command is accepted on a rising edge where `cmd_valid` && `cmd_ready`. When `cmd_valid` is high and `cmd_ready` is low, the command is ignored and not queued.
- Opcodes, with the effect on `tags` at the accept edge:
  - 0 NOP: no change.
  - 1 SET_ALL: all ones.
  - 2 CLR_ALL: all zeros.
  - 3 AND_MATCH: `tags & match_lines`.
  - 4 OR_MATCH: `tags | match_lines`.
  - 5 SELECT_FIRST: keep only the lowest set bit. No change if none is set.
  - 6 STEP: clear the lowest set bit. No change if none is set.
  - 7 COUNT: `tags` unchanged; starts a popcount.
- `first_idx` comes from a priority encoder with the lowest index winning. `some` = |`tags`.
- FSM states:
  - IDLE: `cmd_ready` = 1. Accepting COUNT moves to CNT, clears the chunk pointer and the accumulator.
  - CNT: `cmd_ready` = 0. Each edge adds popcount(`tags[ptr*CHUNK +: CHUNK]`) to the accumulator and increments the pointer. Bits at or above WORDS in the last chunk count as 0.
  - CNT exit: on the edge that processes chunk ceil(WORDS/CHUNK)−1, load `count` with accumulator + that chunk, pulse `count_valid`, and return to IDLE.
- `tags` cannot change during CNT, because no commands are accepted there. The count therefore reflects `tags` at the accept edge.
- `count` holds its value until the next COUNT completes.

## Timing
- Reset values (asynchronous on RST_N = 0):
  - `tags` = 0, `some` = 0, `first_idx` = 0
  - `count` = 0, `count_valid` = 0
  - `cmd_ready` = 1, state IDLE
- Single-cycle ops: a command accepted at edge E0 shows its result on `tags`, `some` and `first_idx` right after E0. Back-to-back commands every cycle are allowed.
- COUNT:
  - Accepted at E0. Chunk edges are E1 through EN, with N = ceil(WORDS/CHUNK) (13 at defaults).
  - `cmd_ready` = 0 from after E0 until after EN.
  - `count` and `count_valid` = 1 during the cycle after EN.
  - `cmd_ready` = 1 in that same cycle, so a new command can be accepted at EN+1.
- `match_lines` must be stable at the accept edge. Its value in any other cycle is ignored.
- RST_N asserted mid-CNT: the count aborts, state goes to IDLE, and `count_valid` is not pulsed. All outputs return to reset values.
- Reset deassertion is synchronised externally. The first command may be accepted on the first edge after RST_N rises.

## Test plan
- Reset: drive RST_N = 0 mid-simulation with arbitrary state → `tags` = 0, `some` = 0, `first_idx` = 0, `count` = 0, `cmd_ready` = 1 immediately, without waiting for a clock edge.
- Narrowing: SET_ALL, then AND_MATCH with `match_lines` bits {3, 7, 50} set → `tags` has exactly those bits, `some` = 1, `first_idx` = 3.
- Stepping:
  - STEP → `first_idx` = 7.
  - STEP → `first_idx` = 50.
  - STEP → `some` = 0, `first_idx` = 0.
  - Further STEP → `tags` stays 0.
- Select/OR: CLR_ALL, OR_MATCH with bits {99, 10} set, SELECT_FIRST → `tags` has only bit 10 set, `first_idx` = 10.
- Count:
  - SET_ALL, then COUNT → `cmd_ready` low for 13 cycles, then `count` = 100 with a one-cycle `count_valid`.
  - Keep `cmd_valid` high with CLR_ALL during CNT → CLR_ALL is ignored and `count` is still 100.
  - After the count completes, CLR_ALL then COUNT → `count` = 0.
- Abort: start COUNT with `tags` all set, assert RST_N at chunk 5 → no `count_valid` pulse, `count` = 0, state IDLE. A fresh SET_ALL then COUNT yields 100.
